j68_flag_unit: RTL and testbench
================================

# j68_flag_unit

Parametrised condition-code unit for the j68 CPU core, the successor to the fixed 16-bit-datapath flag block. It derives X/N/Z/V/C from ALU results delivered in CHUNK-bit slices, so long operations on a 16-bit datapath and single-pass operation on a 32-bit datapath both work. It also holds the carry-in register and adds a LIFO shadow stack for CCR save/restore on exception entry and return. It sits between the ALU/shifter and the microcode sequencer's test block.

## Interface
- CHUNK, 16: ALU result slice width, 16 or 32.
- SAVE_DEPTH, 4: CCR shadow-stack entries, power of two, 2..16.
- clk  in  1  CPU clock.
- rst  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- clk_ena  in  1  clock enable; when 0, no register changes (reset still applies).
- l_size  in  2  operand size: 00 byte, 01 word, 1x long.
- l_alu  in  2  unit select: 00 adder, 01 logic, 10 left shifter, 11 right shifter/divide.
- div_v  in  1  qualifier for the divide overflow.
- c_add / v_add  in  3 each  adder carry/overflow per size (bit0 byte, bit1 word, bit2 long).
- c_shf / v_shf  in  3 each  shifter carry/overflow per size.
- l_res  in  CHUNK  latched result slice.
- z_acc  in  1  0: Z accumulator restarts on this slice; 1: AND with the previous slices.
- a_src, b_src  in  CHUNK each  operands for carry-in selection.
- flg_c  in  11  per-flag control: C[1:0], V[3:2], Z[6:4], N[8:7], X[10:9].
- cin_c  in  4  carry-in select.
- ccr_wr  in  1  direct CCR load from ccr_din.
- ccr_din  in  5  XNZVC value for the direct load.
- push, pop  in  1 each  shadow-stack controls.
- stk_clr  in  1  empties the stack and clears its error flags.
- cc_out  out  5  XNZVC.
- c_in  out  1  registered ALU carry-in.
- z_flg  out  1  slice zero (combinational).
- g_flg  out  1  signed-greater on the current slice (combinational).
- stk_cnt  out  clog2(SAVE_DEPTH)+1  number of occupied stack entries.
- stk_ovf, stk_unf  out  1 each  sticky overflow / underflow.

## Operation
- Flag derivation:
  - Adder: C = c_add[size], V = v_add[size].
  - Logic: C = 0, V = 0.
  - Left shifter: C = c_shf[size], V = v_shf[size].
  - Right shifter: C = c_shf[size], V = v_flg_div & div_v.
- N is taken from the slice MSB for the selected size: l_res[7] for byte, l_res[15] for word, l_res[CHUNK-1] for long. For a long on a 16-bit datapath, the last slice carries the high word.
- Z:
  - slice zero zs covers bits [7:0] for byte, [15:0] for word, and the full slice for long.
  - With z_acc=1: Z = zs & zacc_r. With z_acc=0: Z = zs.
  - zacc_r <= Z on every enabled cycle.
- Per-flag control codes: 00 keep, 01 update, 10 clear, 11 set.
  - Z uses a 3-bit code; when bit2=1 and low bits are 01, Z <= Z & cc_out[2] (sticky, clear-only for extended arithmetic). Other bit2 codes behave as their 2-bit equivalents.
- Carry-in select codes (cin_c):
  - 0 keep
  - 1 zero
  - 2 c_add[1]
  - 3 derived C
  - 4 X
  - 5 l_res[7]
  - 6 l_res[15]
  - 7 N
  - 8 a_src[0]
  - 9 a_src[7]
  - A a_src[15]
  - B a_src[CHUNK-1]
  - C b_src[0]
  - D b_src[7]
  - E b_src[15]
  - F b_src[CHUNK-1]
- CCR write priority, highest first: rst, pop, ccr_wr, flg_c.
- push captures cc_out as it was before this cycle's update.
- push + ccr_wr in one cycle: the old CCR is saved and ccr_din is loaded (exception entry).
- pop loads cc_out from the top entry; flg_c and ccr_wr are ignored that cycle.
- push + pop in one cycle: the top entry is swapped with the current CCR; stk_cnt is unchanged.
- Stack full + push (without pop): entry dropped, stk_ovf <= 1, stk_cnt unchanged.
- Stack empty + pop: cc_out unchanged, stk_unf <= 1. A simultaneous push is treated as a normal push.
- stk_clr has priority over push and pop: stk_cnt <= 0 and both sticky flags clear; CCR updates proceed normally.

## Timing
- Reset values (applied on a rst edge regardless of clk_ena):
  - cc_out = 5'b00100
  - c_in = 0
  - zacc_r = 0
  - stk_cnt = 0
  - stk_ovf = stk_unf = 0
- cc_out, c_in and the stack update on the clk edge where clk_ena=1; results are visible the next cycle (latency 1).
- z_flg and g_flg are combinational from the current inputs (latency 0).
- Long operation on CHUNK=16: slice0 with z_acc=0, then slice1 with z_acc=1. Flags are committed on the slice1 cycle.
- rst asserted mid-sequence discards the accumulator and stack contents.

## Structure
- Package j68_flag_pkg holds:
  - size encodings
  - flag-control codes
  - cin_c codes
  - the XNZVC bit indices
- Sub-module j68_flag_stack: parametrised LIFO of 5-bit entries with push/pop/swap/clr, count and sticky errors. It is the only sub-module; flag derivation stays in the top level.

## Test plan
- Reset, then idle with clk_ena=0 -> cc_out=00100, c_in=0, stk_cnt=0.
- CHUNK=16 long add: slice0 0x0000, z_acc=0; slice1 0x0000, z_acc=1; flg_c Z=001 -> Z=1. Repeat with slice0=0x0001 -> Z=0.
- Sticky Z: cc_out Z=1, flg_c Z=101, result 0x0001 -> Z=0; next cycle result 0x0000 -> Z stays 0.
- SAVE_DEPTH=4: five pushes of distinct CCR values -> stk_cnt=4, stk_ovf=1; four pops return the first four values in reverse order; a fifth pop -> stk_unf=1, cc_out unchanged.
- push+ccr_wr with CCR=0x1F, ccr_din=0x04 -> cc_out=0x04, top=0x1F; push+pop then swaps them.
- cin_c=F with b_src=0x8000_0000 and CHUNK=32 -> c_in=1 next cycle. cin_c=0 then holds c_in at 1.

Source files
------------

// File: rtl/j68_flag_pkg.sv
// Shared encodings for the j68 condition-code unit: sizes, unit selects,
// per-flag control codes, carry-in select codes and CCR bit positions.
package j68_flag_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_LOG = 2'b01,
    ALU_SHL = 2'b10,
    ALU_SHR = 2'b11
  } alu_e;

  localparam logic [1:0] FC_KEEP = 2'b00;
  localparam logic [1:0] FC_UPD  = 2'b01;
  localparam logic [1:0] FC_CLR  = 2'b10;
  localparam logic [1:0] FC_SET  = 2'b11;
  localparam logic [2:0] ZC_STICKY = 3'b101;

  localparam logic [3:0] CIN_KEEP = 4'h0;
  localparam logic [3:0] CIN_ZERO = 4'h1;
  localparam logic [3:0] CIN_CADD = 4'h2;
  localparam logic [3:0] CIN_CDER = 4'h3;
  localparam logic [3:0] CIN_X    = 4'h4;
  localparam logic [3:0] CIN_R7   = 4'h5;
  localparam logic [3:0] CIN_R15  = 4'h6;
  localparam logic [3:0] CIN_N    = 4'h7;
  localparam logic [3:0] CIN_A0   = 4'h8;
  localparam logic [3:0] CIN_A7   = 4'h9;
  localparam logic [3:0] CIN_A15  = 4'hA;
  localparam logic [3:0] CIN_AHI  = 4'hB;
  localparam logic [3:0] CIN_B0   = 4'hC;
  localparam logic [3:0] CIN_B7   = 4'hD;
  localparam logic [3:0] CIN_B15  = 4'hE;
  localparam logic [3:0] CIN_BHI  = 4'hF;

  localparam int CC_X = 4;
  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  function automatic logic apply_fc(input logic [1:0] code, input logic cur, input logic upd);
    case (code)
      FC_KEEP: return cur;
      FC_UPD:  return upd;
      FC_CLR:  return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/j68_flag_stack.sv
// LIFO of 5-bit CCR snapshots with push, pop, push+pop swap, clear,
// occupancy count and sticky overflow/underflow flags.
module j68_flag_stack
  import j68_flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [4:0]               din,
  output logic [4:0]               top,
  output logic                     pop_ok,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf,
  output logic                     unf
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [4:0]    mem_reg [DEPTH];
  logic [CW-1:0] cnt_reg;
  logic          ovf_reg;
  logic          unf_reg;
  logic          empty;
  logic          full;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;

  assign empty   = (cnt_reg == '0);
  assign full    = (cnt_reg == CW'(DEPTH));
  assign top_idx = IW'(cnt_reg - CW'(1));
  assign wr_idx  = cnt_reg[IW-1:0];
  assign top     = mem_reg[top_idx];
  assign pop_ok  = pop & ~clr & ~empty;
  assign cnt     = cnt_reg;
  assign ovf     = ovf_reg;
  assign unf     = unf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (ena) begin
      if (clr) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
        unf_reg <= 1'b0;
      end else if (push && !(pop && !empty)) begin
        if (full) ovf_reg <= 1'b1;
        else      cnt_reg <= cnt_reg + CW'(1);
      end else if (pop && !push) begin
        if (empty) unf_reg <= 1'b1;
        else       cnt_reg <= cnt_reg - CW'(1);
      end
    end
  end

  // Storage carries no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && ena && !clr && push) begin
      if (pop && !empty) mem_reg[top_idx] <= din;
      else if (!full)    mem_reg[wr_idx]  <= din;
    end
  end

endmodule

// File: rtl/j68_flag_unit.sv
// j68 condition-code unit: XNZVC derivation from CHUNK-bit result slices,
// ALU carry-in register and a CCR shadow stack for exception entry/return.
module j68_flag_unit
  import j68_flag_pkg::*;
#(
  parameter int CHUNK      = 16,
  parameter int SAVE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_ena,
  input  logic [1:0]                    l_size,
  input  logic [1:0]                    l_alu,
  input  logic                          div_v,
  input  logic [2:0]                    c_add,
  input  logic [2:0]                    v_add,
  input  logic [2:0]                    c_shf,
  input  logic [2:0]                    v_shf,
  input  logic [CHUNK-1:0]              l_res,
  input  logic                          z_acc,
  input  logic [CHUNK-1:0]              a_src,
  input  logic [CHUNK-1:0]              b_src,
  input  logic [10:0]                   flg_c,
  input  logic [3:0]                    cin_c,
  input  logic                          ccr_wr,
  input  logic [4:0]                    ccr_din,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          stk_clr,
  output logic [4:0]                    cc_out,
  output logic                          c_in,
  output logic                          z_flg,
  output logic                          g_flg,
  output logic [$clog2(SAVE_DEPTH):0]   stk_cnt,
  output logic                          stk_ovf,
  output logic                          stk_unf
);
  logic [4:0] cc_reg, cc_next;
  logic       c_in_reg, c_in_next;
  logic       zacc_reg;
  logic [1:0] sz_idx;
  logic       c_der, v_der, n_der, zs, z_der;
  logic [4:0] stk_top;
  logic       pop_ok, pop_req;

  assign sz_idx = l_size[1] ? 2'd2 : {1'b0, l_size[0]};

  always_comb begin
    c_der = 1'b0;
    v_der = 1'b0;
    case (alu_e'(l_alu))
      ALU_ADD: begin c_der = c_add[sz_idx]; v_der = v_add[sz_idx]; end
      ALU_LOG: begin c_der = 1'b0;          v_der = 1'b0;          end
      ALU_SHL: begin c_der = c_shf[sz_idx]; v_der = v_shf[sz_idx]; end
      ALU_SHR: begin c_der = c_shf[sz_idx]; v_der = v_shf[sz_idx] & div_v; end
      default: ;
    endcase
  end

  always_comb begin
    n_der = l_res[CHUNK-1];
    zs    = ~|l_res;
    if (l_size == SZ_BYTE) begin
      n_der = l_res[7];
      zs    = ~|l_res[7:0];
    end else if (l_size == SZ_WORD) begin
      n_der = l_res[15];
      zs    = ~|l_res[15:0];
    end
  end

  assign z_der = z_acc ? (zs & zacc_reg) : zs;
  assign z_flg = z_der;
  assign g_flg = ~z_der & ~(n_der ^ v_der);

  // An empty-stack pop paired with a push is just a push, so it does not freeze the CCR.
  assign pop_req = pop & ~stk_clr & ~(push & (stk_cnt == '0));

  always_comb begin
    cc_next = cc_reg;
    if (pop_req) begin
      if (pop_ok) cc_next = stk_top;
    end else if (ccr_wr) begin
      cc_next = ccr_din;
    end else begin
      cc_next[CC_C] = apply_fc(flg_c[1:0], cc_reg[CC_C], c_der);
      cc_next[CC_V] = apply_fc(flg_c[3:2], cc_reg[CC_V], v_der);
      cc_next[CC_N] = apply_fc(flg_c[8:7], cc_reg[CC_N], n_der);
      cc_next[CC_X] = apply_fc(flg_c[10:9], cc_reg[CC_X], c_der);
      if (flg_c[6:4] == ZC_STICKY) cc_next[CC_Z] = z_der & cc_reg[CC_Z];
      else cc_next[CC_Z] = apply_fc(flg_c[5:4], cc_reg[CC_Z], z_der);
    end
  end

  always_comb begin
    c_in_next = c_in_reg;
    case (cin_c)
      CIN_KEEP: c_in_next = c_in_reg;
      CIN_ZERO: c_in_next = 1'b0;
      CIN_CADD: c_in_next = c_add[1];
      CIN_CDER: c_in_next = c_der;
      CIN_X:    c_in_next = cc_reg[CC_X];
      CIN_R7:   c_in_next = l_res[7];
      CIN_R15:  c_in_next = l_res[15];
      CIN_N:    c_in_next = cc_reg[CC_N];
      CIN_A0:   c_in_next = a_src[0];
      CIN_A7:   c_in_next = a_src[7];
      CIN_A15:  c_in_next = a_src[15];
      CIN_AHI:  c_in_next = a_src[CHUNK-1];
      CIN_B0:   c_in_next = b_src[0];
      CIN_B7:   c_in_next = b_src[7];
      CIN_B15:  c_in_next = b_src[15];
      default:  c_in_next = b_src[CHUNK-1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_reg   <= 5'b00100;
      c_in_reg <= 1'b0;
      zacc_reg <= 1'b0;
    end else if (clk_ena) begin
      cc_reg   <= cc_next;
      c_in_reg <= c_in_next;
      zacc_reg <= z_der;
    end
  end

  assign cc_out = cc_reg;
  assign c_in   = c_in_reg;

  j68_flag_stack #(.DEPTH(SAVE_DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .ena    (clk_ena),
    .push   (push),
    .pop    (pop),
    .clr    (stk_clr),
    .din    (cc_reg),
    .top    (stk_top),
    .pop_ok (pop_ok),
    .cnt    (stk_cnt),
    .ovf    (stk_ovf),
    .unf    (stk_unf)
  );

endmodule

// File: tb/tb_j68_flag_unit.sv
// Directed bench for j68_flag_unit: a 16-bit-slice instance and a 32-bit-slice
// instance share stimulus; expected values are hand-computed constants.
module tb_j68_flag_unit;
  logic        clk = 1'b0;
  logic        rst, clk_ena, div_v, z_acc, ccr_wr, push, pop, stk_clr;
  logic [1:0]  l_size, l_alu;
  logic [2:0]  c_add, v_add, c_shf, v_shf;
  logic [31:0] l_res, a_src, b_src;
  logic [10:0] flg_c;
  logic [3:0]  cin_c;
  logic [4:0]  ccr_din;

  logic [4:0]  cc16, cc32;
  logic        cin16, cin32, z16, z32, g16, g32;
  logic [2:0]  cnt16, cnt32;
  logic        ovf16, ovf32, unf16, unf32;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] vals [6];

  always #5 clk = ~clk;

  j68_flag_unit #(.CHUNK(16), .SAVE_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst), .clk_ena(clk_ena), .l_size(l_size), .l_alu(l_alu),
    .div_v(div_v), .c_add(c_add), .v_add(v_add), .c_shf(c_shf), .v_shf(v_shf),
    .l_res(l_res[15:0]), .z_acc(z_acc), .a_src(a_src[15:0]), .b_src(b_src[15:0]),
    .flg_c(flg_c), .cin_c(cin_c), .ccr_wr(ccr_wr), .ccr_din(ccr_din),
    .push(push), .pop(pop), .stk_clr(stk_clr),
    .cc_out(cc16), .c_in(cin16), .z_flg(z16), .g_flg(g16),
    .stk_cnt(cnt16), .stk_ovf(ovf16), .stk_unf(unf16)
  );

  j68_flag_unit #(.CHUNK(32), .SAVE_DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .clk_ena(clk_ena), .l_size(l_size), .l_alu(l_alu),
    .div_v(div_v), .c_add(c_add), .v_add(v_add), .c_shf(c_shf), .v_shf(v_shf),
    .l_res(l_res), .z_acc(z_acc), .a_src(a_src), .b_src(b_src),
    .flg_c(flg_c), .cin_c(cin_c), .ccr_wr(ccr_wr), .ccr_din(ccr_din),
    .push(push), .pop(pop), .stk_clr(stk_clr),
    .cc_out(cc32), .c_in(cin32), .z_flg(z32), .g_flg(g32),
    .stk_cnt(cnt32), .stk_ovf(ovf32), .stk_unf(unf32)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    flg_c = '0; cin_c = 4'h0; ccr_wr = 0; ccr_din = '0;
    push = 0; pop = 0; stk_clr = 0; z_acc = 0;
  endtask

  initial begin
    rst = 1; clk_ena = 0; div_v = 0; l_size = 2'b10; l_alu = 2'b00;
    c_add = '0; v_add = '0; c_shf = '0; v_shf = '0;
    l_res = '0; a_src = '0; b_src = '0;
    idle_ctl();
    vals[0] = 5'h01; vals[1] = 5'h02; vals[2] = 5'h03;
    vals[3] = 5'h05; vals[4] = 5'h08; vals[5] = 5'h11;

    // reset applies even without clock enable, then an idle disabled cycle
    tick();
    rst = 0;
    ccr_wr = 1; ccr_din = 5'h1F;
    tick();
    check_val("rst_cc16", cc16, 5'h04);
    check_val("rst_cc32", cc32, 5'h04);
    check_val("rst_cin", cin16, 0);
    check_val("rst_cnt", cnt16, 0);
    check_val("rst_errs", {ovf16, unf16}, 0);

    clk_ena = 1;
    ccr_din = 5'h00;
    tick();
    check_val("ccr_wr_zero", cc16, 5'h00);
    ccr_wr = 0;

    // two-slice long on the 16-bit datapath
    l_size = 2'b10; l_alu = 2'b00;
    l_res = 32'h0; z_acc = 0; flg_c = 11'h000; tick();
    l_res = 32'h0; z_acc = 1; flg_c = 11'h010; tick();
    check_val("long_z_set", cc16, 5'h04);
    l_res = 32'h1; z_acc = 0; flg_c = 11'h000; tick();
    l_res = 32'h0; z_acc = 1; flg_c = 11'h010; tick();
    check_val("long_z_clr", cc16, 5'h00);
    // all-flag update, high-word sign, long carry/overflow
    l_res = 32'h0; z_acc = 0; flg_c = 11'h000; tick();
    l_res = 32'h8000; z_acc = 1; flg_c = 11'h295; c_add = 3'b100; v_add = 3'b100; tick();
    check_val("long_xnvc", cc16, 5'h1B);
    c_add = '0; v_add = '0;
    idle_ctl();

    // combinational slice flags
    l_alu = 2'b01; l_size = 2'b01; l_res = 32'h0005; #1;
    check_val("g_pos", g16, 1);
    check_val("z_nonzero", z16, 0);
    l_res = 32'h8000; #1;
    check_val("g_neg", g16, 0);
    l_size = 2'b00; l_res = 32'h0100; #1;
    check_val("z_byte_ignores_hi", z16, 1);
    l_size = 2'b10; l_res = 32'h0001_0000; #1;
    check_val("z32_long", z32, 0);
    check_val("z16_long", z16, 1);

    // sticky Z
    l_size = 2'b01;
    ccr_wr = 1; ccr_din = 5'h04; tick(); ccr_wr = 0;
    flg_c = 11'h050; l_res = 32'h1; tick();
    check_val("sticky_z_clr", cc16, 5'h00);
    l_res = 32'h0; tick();
    check_val("sticky_z_hold", cc16, 5'h00);
    idle_ctl();

    // shadow stack: five pushes into four entries
    ccr_wr = 1; ccr_din = vals[0]; tick();
    for (int i = 0; i < 5; i++) begin
      push = 1; ccr_din = vals[i+1]; tick();
    end
    idle_ctl();
    check_val("push_cnt", cnt16, 4);
    check_val("push_ovf", ovf16, 1);
    check_val("push_cc", cc16, vals[5]);
    for (int i = 3; i >= 0; i--) begin
      pop = 1; ccr_wr = (i == 2); ccr_din = 5'h1F; tick();
      check_val($sformatf("pop%0d_cc", i), cc16, vals[i]);
      check_val($sformatf("pop%0d_cnt", i), cnt16, 3'(i));
    end
    pop = 1; ccr_wr = 0; tick();
    check_val("pop_empty_unf", unf16, 1);
    check_val("pop_empty_cc", cc16, vals[0]);
    idle_ctl();
    stk_clr = 1; tick(); stk_clr = 0;
    check_val("clr_errs", {ovf16, unf16}, 0);

    // exception entry and swap
    ccr_wr = 1; ccr_din = 5'h1F; tick();
    push = 1; ccr_din = 5'h04; tick();
    check_val("entry_cc", cc16, 5'h04);
    check_val("entry_cnt", cnt16, 1);
    ccr_wr = 0; push = 1; pop = 1; tick();
    check_val("swap_cc", cc16, 5'h1F);
    check_val("swap_cnt", cnt16, 1);
    push = 0; pop = 1; tick();
    check_val("swap_top", cc16, 5'h04);
    idle_ctl();

    // carry-in select
    cin_c = 4'hF; b_src = 32'h8000_0000; tick();
    check_val("cin32_bhi", cin32, 1);
    check_val("cin16_bhi", cin16, 0);
    cin_c = 4'h0; b_src = 32'h0; tick();
    check_val("cin_keep", cin32, 1);
    cin_c = 4'h1; tick();
    check_val("cin_zero", cin32, 0);
    cin_c = 4'h2; c_add = 3'b010; tick();
    check_val("cin_cadd", cin16, 1);
    c_add = '0; idle_ctl();

    // clock enable low freezes, reset mid-sequence empties the stack
    push = 1; tick();
    clk_ena = 0; push = 0; ccr_wr = 1; ccr_din = 5'h0A; tick();
    check_val("ena_hold_cc", cc16, 5'h04);
    check_val("ena_hold_cnt", cnt16, 1);
    rst = 1; tick(); rst = 0; ccr_wr = 0;
    check_val("mid_rst_cnt", cnt16, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
